fault_detector: RTL and testbench
=================================

# fault_detector

Runtime fault observer for the fault-simulation datapath. Receives per-cycle result samples from the golden (fault-free) ALU and the fault-injected ALU, compares them, and classifies each mismatch. Every detected fault is logged with its sample index into a small FIFO, which software or the testbench drains over a ready/valid port. Sticky summary status is also provided.

## Interface
Parameters:
- DATA_W, 32, width of compared result words
- DEPTH, 8, fault-log FIFO entries (power of two, ≥2)
- CYC_W, 16, width of sample counter and logged sample index

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  monitoring enable; a rising edge starts a new session
- in_valid  in  1  a golden/DUT sample pair is present this cycle
- golden_result  in  DATA_W  fault-free ALU result
- dut_result  in  DATA_W  fault-injected ALU result
- golden_zero  in  1  fault-free Zero flag
- dut_zero  in  1  fault-injected Zero flag
- log_valid  out  1  FIFO head record available
- log_ready  in  1  consumer accepts head record
- log_index  out  CYC_W  sample index of head record
- log_golden  out  DATA_W  golden result of head record
- log_dut  out  DATA_W  DUT result of head record
- log_class  out  2  fault class of head record
- fault_seen  out  1  sticky: at least one fault in this session
- first_fault_index  out  CYC_W  sample index of first fault
- mismatch_count  out  CYC_W  faults detected, saturating
- log_overflow  out  1  sticky: a fault was dropped because the FIFO was full
- state  out  2  FSM state, for debug

## Operation
- FSM states: IDLE=0, ARMED=1, FAULTED=2.
  - IDLE→ARMED when enable=1 and enable was 0 the previous cycle. The same edge clears the sample counter, mismatch_count, first_fault_index, fault_seen, log_overflow, and FIFO contents. It also clears prev_valid.
  - ARMED→FAULTED on the first detected fault.
  - ARMED or FAULTED→IDLE whenever enable=0. Status and FIFO are retained. The FIFO stays drainable in IDLE.
- A sample is accepted when in_valid=1 and state≠IDLE. Samples presented in IDLE are ignored.
- Sample index = number of samples accepted earlier in the session. The first sample is index 0. The counter saturates at 2^CYC_W−1.
- Classification of an accepted sample, in priority order:
  - If results differ and prev_valid=1 and dut_result equals the previous accepted golden_result → DELAY (2'b01).
  - Otherwise, if results differ → VALUE (2'b11).
  - If results are equal but the zero flags differ → FLAG (2'b10).
  - Otherwise → no fault (2'b00). No fault is never logged.
- Each accepted sample stores golden_result as prev_golden and sets prev_valid=1.
- On a fault:
  - mismatch_count increments, saturating at all ones.
  - On the first fault only: fault_seen=1 and first_fault_index=index.
  - The record {index, golden, dut, class} is pushed into the FIFO. If the FIFO is full, the record is dropped and log_overflow=1. The counters still update.
- FIFO read: a record pops when log_valid && log_ready. The log_* outputs show the head record and are stable while log_valid=1 && log_ready=0.
- Push and pop in the same cycle:
  - If the FIFO is full, both are performed: a slot frees and the push succeeds with no overflow.
  - If the FIFO is empty, only the push takes effect. There is no bypass.
- Pointers wrap modulo DEPTH. Full and empty are tracked with an occupancy count of width log2(DEPTH)+1.

## Timing
- Reset: state=IDLE, log_valid=0, log_* =0, fault_seen=0, first_fault_index=0, mismatch_count=0, log_overflow=0. prev_valid=0, FIFO empty.
- Reset asserted mid-session aborts immediately. Every output returns to its reset value, and logged records are lost.
- Comparison is combinational on the inputs. All status and FIFO updates occur at the edge that accepts the sample.
  - A fault on the sample accepted at edge k shows mismatch_count, fault_seen and log_valid after edge k. This is 1-cycle latency.
- The enable rising edge is detected one cycle late, against the registered enable. A sample in that detection cycle is ignored because state is still IDLE.
- log_valid deasserts the cycle after the last record pops.

## Structure
- Shared package fault_pkg:
  - enum fault_class_t with values NONE, DELAY, FLAG, VALUE, encoded as above.
  - enum fd_state_t.
  - packed struct fault_rec_t {index, golden, dut, class}.
- Sub-module fault_log_fifo: a synchronous FIFO of fault_rec_t, depth DEPTH. It exposes push, pop, full, empty and head. The classifier, counters and FSM stay in fault_detector.

## Test plan
- Basic mismatch: enable rises, then accepted samples golden=9/dut=9, golden=9/dut=4 → one record {index 1, 9, 4, VALUE}. Expect fault_seen=1, first_fault_index=1, mismatch_count=1, state=FAULTED.
- Delay detection: goldens 9, 1 with duts 9, 9 → record {index 1, 1, 9, DELAY}. Repeat with prev_valid=0 (first sample of session mismatching) → VALUE.
- Flag fault: golden=0/dut=0 with golden_zero=1/dut_zero=0 → FLAG record. Equal results with equal flags → no record, count unchanged.
- Overflow: DEPTH+2 consecutive VALUE faults with log_ready=0 → DEPTH records held, log_overflow=1, mismatch_count=DEPTH+2. Drain all → indices 0…DEPTH−1 in order, then log_valid=0. Full FIFO with simultaneous push and pop → no overflow.
- Session control: drop enable mid-run → samples ignored and FIFO still drainable. Re-raise enable → all status cleared and index restarts at 0.
- Reset mid-operation: assert rst with 3 records queued → all outputs at reset values within the same cycle. After release, state=IDLE and log_valid=0.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared types for the fault observer: fault classes, FSM states and the log record.
package fault_pkg;

    // Record field widths; fault_detector parameters default to these.
    localparam int unsigned FD_DATA_W = 32;
    localparam int unsigned FD_CYC_W  = 16;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        DELAY = 2'b01,
        FLAG  = 2'b10,
        VALUE = 2'b11
    } fault_class_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        FAULTED = 2'b10
    } fd_state_t;

    typedef struct packed {
        logic [FD_CYC_W-1:0]  index;
        logic [FD_DATA_W-1:0] golden;
        logic [FD_DATA_W-1:0] dut;
        fault_class_t         cls;
    } fault_rec_t;

endpackage

// File: rtl/fault_log_fifo.sv
// Synchronous FIFO of fault records with occupancy-count full/empty tracking.
module fault_log_fifo
    import fault_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  fault_rec_t din,
    output logic       full,
    output logic       empty,
    output fault_rec_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fault_rec_t         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage write; contents are never read while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fault_detector.sv
// Compares golden and fault-injected ALU samples, classifies mismatches, and logs them.
module fault_detector
    import fault_pkg::*;
#(
    parameter int unsigned DATA_W = FD_DATA_W,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CYC_W  = FD_CYC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] golden_result,
    input  logic [DATA_W-1:0] dut_result,
    input  logic              golden_zero,
    input  logic              dut_zero,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [CYC_W-1:0]  log_index,
    output logic [DATA_W-1:0] log_golden,
    output logic [DATA_W-1:0] log_dut,
    output logic [1:0]        log_class,
    output logic              fault_seen,
    output logic [CYC_W-1:0]  first_fault_index,
    output logic [CYC_W-1:0]  mismatch_count,
    output logic              log_overflow,
    output logic [1:0]        state
);

    fd_state_t          state_q;
    logic               enable_q;
    logic [CYC_W-1:0]   sample_cnt_q;
    logic [CYC_W-1:0]   mismatch_q;
    logic [CYC_W-1:0]   first_idx_q;
    logic               fault_seen_q;
    logic               overflow_q;
    logic               prev_valid_q;
    logic [DATA_W-1:0]  prev_golden_q;

    fault_class_t       cls;
    logic               start;
    logic               accept;
    logic               is_fault;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    fault_rec_t         rec;
    fault_rec_t         head;

    // Session start is an enable rising edge seen against the registered enable.
    assign start    = enable && !enable_q && (state_q == IDLE);
    assign accept   = in_valid && (state_q != IDLE);
    assign is_fault = accept && (cls != NONE);
    assign pop      = log_valid && log_ready;

    // Classify the current sample; a DUT result matching the previous golden is a delay fault.
    always_comb begin
        cls = NONE;
        if (golden_result != dut_result) begin
            if (prev_valid_q && (dut_result == prev_golden_q)) cls = DELAY;
            else                                               cls = VALUE;
        end else if (golden_zero != dut_zero) begin
            cls = FLAG;
        end
    end

    // Assemble the record for the current sample.
    always_comb begin
        rec        = '0;
        rec.index  = sample_cnt_q;
        rec.golden = golden_result;
        rec.dut    = dut_result;
        rec.cls    = cls;
    end

    fault_log_fifo #(
        .DEPTH (DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .push  (is_fault),
        .pop   (pop),
        .din   (rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Session FSM plus sample counter, sticky status and previous-sample history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            sample_cnt_q  <= '0;
            mismatch_q    <= '0;
            first_idx_q   <= '0;
            fault_seen_q  <= 1'b0;
            overflow_q    <= 1'b0;
            prev_valid_q  <= 1'b0;
            prev_golden_q <= '0;
        end else begin
            enable_q <= enable;
            if (start) begin
                state_q      <= ARMED;
                sample_cnt_q <= '0;
                mismatch_q   <= '0;
                first_idx_q  <= '0;
                fault_seen_q <= 1'b0;
                overflow_q   <= 1'b0;
                prev_valid_q <= 1'b0;
            end else begin
                if (accept) begin
                    if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + 1'b1;
                    prev_golden_q <= golden_result;
                    prev_valid_q  <= 1'b1;
                end
                if (is_fault) begin
                    if (mismatch_q != '1) mismatch_q <= mismatch_q + 1'b1;
                    if (!fault_seen_q) begin
                        fault_seen_q <= 1'b1;
                        first_idx_q  <= sample_cnt_q;
                    end
                    if (fifo_full && !pop) overflow_q <= 1'b1;
                end
                if (!enable) begin
                    state_q <= IDLE;
                end else if ((state_q == ARMED) && is_fault) begin
                    state_q <= FAULTED;
                end
            end
        end
    end

    // Head record is masked to zero while the log is empty.
    always_comb begin
        log_valid  = !fifo_empty;
        log_index  = fifo_empty ? '0 : head.index;
        log_golden = fifo_empty ? '0 : head.golden;
        log_dut    = fifo_empty ? '0 : head.dut;
        log_class  = fifo_empty ? 2'b00 : head.cls;
    end

    assign fault_seen        = fault_seen_q;
    assign first_fault_index = first_idx_q;
    assign mismatch_count    = mismatch_q;
    assign log_overflow      = overflow_q;
    assign state             = state_q;

endmodule

// File: tb/tb_fault_detector.sv
// Directed, table-driven bench for fault_detector.
module tb_fault_detector;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CYC_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] golden_result = '0;
    logic [DATA_W-1:0] dut_result = '0;
    logic              golden_zero = 1'b0;
    logic              dut_zero = 1'b0;
    logic              log_ready = 1'b0;
    logic              log_valid;
    logic [CYC_W-1:0]  log_index;
    logic [DATA_W-1:0] log_golden;
    logic [DATA_W-1:0] log_dut;
    logic [1:0]        log_class;
    logic              fault_seen;
    logic [CYC_W-1:0]  first_fault_index;
    logic [CYC_W-1:0]  mismatch_count;
    logic              log_overflow;
    logic [1:0]        state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fault_detector #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CYC_W  (CYC_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .in_valid          (in_valid),
        .golden_result     (golden_result),
        .dut_result        (dut_result),
        .golden_zero       (golden_zero),
        .dut_zero          (dut_zero),
        .log_valid         (log_valid),
        .log_ready         (log_ready),
        .log_index         (log_index),
        .log_golden        (log_golden),
        .log_dut           (log_dut),
        .log_class         (log_class),
        .fault_seen        (fault_seen),
        .first_fault_index (first_fault_index),
        .mismatch_count    (mismatch_count),
        .log_overflow      (log_overflow),
        .state             (state)
    );

    typedef struct {
        logic [31:0] g0, d0, g1, d1;
        logic        gz1, dz1;
        int          n;
        logic [15:0] idx;
        logic [1:0]  cls;
        logic [31:0] eg, ed;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] g, input logic [31:0] d, input logic gz,
                          input logic dz);
        in_valid      = 1'b1;
        golden_result = g;
        dut_result    = d;
        golden_zero   = gz;
        dut_zero      = dz;
        step();
        in_valid = 1'b0;
    endtask

    task automatic new_session();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          g0  d0  g1  d1  gz dz  n  idx cls    eg  ed
        vecs[0] = '{9,  9,  9,  4,  0, 0, 1, 1, 2'b11, 9,  4};
        vecs[1] = '{9,  9,  1,  9,  0, 0, 1, 1, 2'b01, 1,  9};
        vecs[2] = '{5,  7,  5,  5,  0, 0, 1, 0, 2'b11, 5,  7};
        vecs[3] = '{3,  3,  0,  0,  1, 0, 1, 1, 2'b10, 0,  0};
        vecs[4] = '{3,  3,  0,  0,  1, 1, 0, 0, 2'b00, 0,  0};
        vecs[5] = '{4,  4,  8,  4,  0, 0, 1, 1, 2'b01, 8,  4};
        vecs[6] = '{2,  3,  5,  2,  0, 0, 2, 0, 2'b11, 2,  3};
        vecs[7] = '{1,  1,  6,  7,  0, 1, 1, 1, 2'b11, 6,  7};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_log_valid", log_valid, 0);
        check("rst_log_index", log_index, 0);
        check("rst_fault_seen", fault_seen, 0);
        check("rst_count", mismatch_count, 0);
        check("rst_overflow", log_overflow, 0);
        check("rst_first", first_fault_index, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Classification table: two samples per fresh session
        for (int i = 0; i < 8; i++) begin
            new_session();
            check($sformatf("v%0d_armed", i), state, 1);
            sample(vecs[i].g0, vecs[i].d0, 1'b0, 1'b0);
            sample(vecs[i].g1, vecs[i].d1, vecs[i].gz1, vecs[i].dz1);
            check($sformatf("v%0d_count", i), mismatch_count, vecs[i].n);
            check($sformatf("v%0d_seen", i), fault_seen, vecs[i].n != 0);
            check($sformatf("v%0d_state", i), state, (vecs[i].n != 0) ? 2 : 1);
            check($sformatf("v%0d_log_valid", i), log_valid, vecs[i].n != 0);
            if (vecs[i].n != 0) begin
                check($sformatf("v%0d_index", i), log_index, vecs[i].idx);
                check($sformatf("v%0d_class", i), log_class, vecs[i].cls);
                check($sformatf("v%0d_golden", i), log_golden, vecs[i].eg);
                check($sformatf("v%0d_dut", i), log_dut, vecs[i].ed);
                check($sformatf("v%0d_first", i), first_fault_index, vecs[i].idx);
            end
        end

        // Overflow: DEPTH+2 faults with no consumer
        new_session();
        log_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) sample(k, k + 100, 1'b0, 1'b0);
        check("ovf_flag", log_overflow, 1);
        check("ovf_count", mismatch_count, DEPTH + 2);
        check("ovf_valid", log_valid, 1);
        check("ovf_head_stable", log_index, 0);
        step();
        check("ovf_head_hold", log_index, 0);
        log_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("drain%0d_valid", k), log_valid, 1);
            check($sformatf("drain%0d_index", k), log_index, k);
            check($sformatf("drain%0d_golden", k), log_golden, k);
            check($sformatf("drain%0d_class", k), log_class, 2'b11);
            step();
        end
        log_ready = 1'b0;
        check("drain_empty", log_valid, 0);
        check("drain_ovf_sticky", log_overflow, 1);

        // Session control: drop enable, status retained
        enable = 1'b0;
        step();
        check("idle_state", state, 0);
        check("idle_ovf_kept", log_overflow, 1);
        check("idle_count_kept", mismatch_count, DEPTH + 2);

        // Re-raise with a fault sample in the detection cycle; it must be ignored
        enable = 1'b1;
        sample(50, 60, 1'b0, 1'b0);
        check("rearm_state", state, 1);
        check("rearm_count", mismatch_count, 0);
        check("rearm_seen", fault_seen, 0);
        check("rearm_ovf", log_overflow, 0);
        check("rearm_valid", log_valid, 0);
        sample(7, 8, 1'b0, 1'b0);
        check("rearm_index", log_index, 0);
        check("rearm_first", first_fault_index, 0);
        check("rearm_count1", mismatch_count, 1);
        sample(7, 7, 1'b0, 1'b0);
        enable = 1'b0;
        step();
        sample(1, 2, 1'b0, 1'b0);
        check("idle_ignored_count", mismatch_count, 1);
        check("idle_ignored_state", state, 0);
        check("idle_drain_valid", log_valid, 1);
        check("idle_drain_golden", log_golden, 7);
        log_ready = 1'b1;
        step();
        log_ready = 1'b0;
        check("idle_drained", log_valid, 0);

        // Full FIFO with simultaneous push and pop
        new_session();
        for (int k = 0; k < DEPTH; k++) sample(k, k + 100, 1'b0, 1'b0);
        in_valid      = 1'b1;
        golden_result = 200;
        dut_result    = 300;
        log_ready     = 1'b1;
        step();
        in_valid  = 1'b0;
        log_ready = 1'b0;
        check("pp_no_ovf", log_overflow, 0);
        check("pp_count", mismatch_count, DEPTH + 1);
        check("pp_head", log_index, 1);
        log_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("pp_drain%0d", k), log_index, k);
            step();
        end
        log_ready = 1'b0;
        check("pp_empty", log_valid, 0);

        // Reset mid-operation with 3 records queued
        new_session();
        for (int k = 0; k < 3; k++) sample(k + 10, k + 20, 1'b0, 1'b0);
        check("mid_valid", log_valid, 1);
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_valid", log_valid, 0);
        check("mid_rst_index", log_index, 0);
        check("mid_rst_golden", log_golden, 0);
        check("mid_rst_count", mismatch_count, 0);
        check("mid_rst_seen", fault_seen, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_state", state, 0);
        check("post_rst_valid", log_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
